multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter ENABLE_M, default 1, meaning MUL/DIV (funct7=0000001 with op 0110011) decoded with multiplier handshake; 0 means treated as plain R-type.
REQ-002 SHALL have parameter TRAP_ON_ILLEGAL, default 1, meaning unknown opcode enters TRAP; 0 means unknown opcode retires as NOP.
REQ-003 SHALL have ports, per line name direction width meaning:
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-high
  op  in  7  opcode from instruction register
  funct3  in  3  instruction [14:12]
  funct7  in  7  instruction [31:25]
  mem_ready  in  1  memory completes the current request this cycle
  mul_done  in  1  multiplier result valid this cycle
  pc_write  out  1  PC register load enable
  ir_write  out  1  instruction/old-PC register load enable
  adr_src  out  1  memory address: 0 PC, 1 ALUOut
  mem_req  out  1  memory request valid
  mem_we  out  1  memory write (only with mem_req)
  reg_write  out  1  register file write enable
  result_src  out  2  00 ALUOut, 01 mem data, 10 ALU result, 11 mul result
  alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1, 11 zero
  alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
  alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded
  branch  out  1  conditional PC update by comparator
  branch_type  out  3  funct3 copy during BRANCH, else 0
  load_type  out  3  funct3 copy during MEMREAD/MEMWB, else 0
  is_jalr  out  1  datapath clears target bit 0
  mul_start  out  1  one-cycle multiplier launch pulse
  illegal_instr  out  1  sticky illegal-opcode flag
  state_o  out  4  current state encoding

Function
REQ-004 SHALL be a Moore FSM, encoding: FETCH0 DECODE1 MEMADR2 MEMREAD3 MEMWB4 MEMWRITE5 EXEC_R6 EXEC_I7 ALUWB8 BRANCH9 JAL10 JALR11 LINK12 UPPER13 MULWAIT14 TRAP15.
REQ-005 SHALL drive every output not listed for a state to 0.
REQ-006 FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10; ir_write=pc_write=1 only in the mem_ready cycle; hold until mem_ready, then DECODE.
REQ-007 DECODE: a=01, b=01, alu_op=00; next: 0000011/0100011->MEMADR, 0110011->EXEC_R, 0010011->EXEC_I, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111/0010111->UPPER, other->TRAP (TRAP_ON_ILLEGAL=1) or FETCH (=0).
REQ-008 MEMADR: a=10, b=01, alu_op=00; ->MEMREAD (load) or MEMWRITE (store).
REQ-009 MEMREAD: mem_req=1, adr_src=1; hold until mem_ready, then MEMWB. MEMWB: result_src=01, reg_write=1 ->FETCH.
REQ-010 MEMWRITE: mem_req=1, mem_we=1, adr_src=1; hold until mem_ready ->FETCH.
REQ-011 EXEC_R: a=10, b=00, alu_op=10; if ENABLE_M and funct7=0000001: mul_start=1 ->MULWAIT, else ->ALUWB.
REQ-012 MULWAIT: hold until mul_done; in the mul_done cycle result_src=11, reg_write=1, ->FETCH.
REQ-013 EXEC_I: a=10, b=01, alu_op=10 ->ALUWB. UPPER: a=11 (LUI) or 01 (AUIPC), b=01, alu_op=00 ->ALUWB. ALUWB: result_src=00, reg_write=1 ->FETCH.
REQ-014 BRANCH: a=10, b=00, alu_op=01, branch=1, result_src=00 ->FETCH.
REQ-015 JAL: a=01, b=01, alu_op=00, result_src=10, pc_write=1 ->LINK. JALR: same but a=10, is_jalr=1 ->LINK.
REQ-016 LINK: a=01, b=10, alu_op=00, result_src=10, reg_write=1 ->FETCH.
REQ-017 TRAP: illegal_instr=1; remains in TRAP until reset; no mem_req, reg_write, pc_write.
REQ-018 mem_ready outside FETCH/MEMREAD/MEMWRITE and mul_done outside MULWAIT SHALL be ignored; a request is held with stable outputs for any number of wait cycles.

Reset
REQ-019 reset high SHALL asynchronously force FETCH and clear illegal_instr; while reset high all outputs except state_o SHALL be 0; first post-release cycle is FETCH.
REQ-020 reset mid-operation (any state, including wait states) SHALL abandon the instruction without further pc_write or reg_write.

Verification
REQ-021 add (op 0110011, funct7 0), mem_ready=1 in FETCH -> states 0,1,6,8,0; reg_write only in state 8.
REQ-022 lw, mem_ready low 3 cycles in MEMREAD -> 0,1,2,3,3,3,3,4; load_type=010; mem_req held constant.
REQ-023 mul (funct7 0000001), mul_done after 5 cycles -> mul_start single pulse, reg_write with result_src=11 once; with ENABLE_M=0 -> path 6->8, no mul_start.
REQ-024 jalr -> pc_write in state 11 with is_jalr=1, reg_write in 12, 5 cycles total.
REQ-025 op 1111111 -> TRAP, illegal_instr=1 held; reset mid-TRAP -> FETCH, flag 0; TRAP_ON_ILLEGAL=0 -> DECODE->FETCH, no writes.

Source files
------------

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32 control FSM with memory and multiplier handshakes
// Moore state register; handshake strobes qualify the current state's outputs combinationally.
module multicycle_controller #(
  parameter bit ENABLE_M        = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       mem_ready,
  input  logic       mul_done,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_req,
  output logic       mem_we,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       branch,
  output logic [2:0] branch_type,
  output logic [2:0] load_type,
  output logic       is_jalr,
  output logic       mul_start,
  output logic       illegal_instr,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_UPPER    = 4'd13,
    S_MULWAIT  = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  state_t r_state;
  logic   r_illegal;
  logic   w_is_mul;

  assign w_is_mul = ENABLE_M && (funct7 == 7'b0000001);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
            OP_R:              r_state <= S_EXEC_R;
            OP_I:              r_state <= S_EXEC_I;
            OP_BR:             r_state <= S_BRANCH;
            OP_JAL:            r_state <= S_JAL;
            OP_JALR:           r_state <= S_JALR;
            OP_LUI, OP_AUIPC:  r_state <= S_UPPER;
            default: begin
              if (TRAP_ON_ILLEGAL) begin
                r_state   <= S_TRAP;
                r_illegal <= 1'b1;
              end else begin
                r_state   <= S_FETCH;
              end
            end
          endcase
        end
        S_MEMADR:   r_state <= (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
        S_EXEC_R:   r_state <= w_is_mul ? S_MULWAIT : S_ALUWB;
        S_EXEC_I:   r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_BRANCH:   r_state <= S_FETCH;
        S_JAL:      r_state <= S_LINK;
        S_JALR:     r_state <= S_LINK;
        S_LINK:     r_state <= S_FETCH;
        S_UPPER:    r_state <= S_ALUWB;
        S_MULWAIT:  if (mul_done) r_state <= S_FETCH;
        S_TRAP:     r_state <= S_TRAP;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Everything is held low while reset is asserted, not just after the state register clears.
  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    branch      = 1'b0;
    branch_type = 3'b000;
    load_type   = 3'b000;
    is_jalr     = 1'b0;
    mul_start   = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          pc_write   = mem_ready;
          ir_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_MEMREAD: begin
          mem_req   = 1'b1;
          adr_src   = 1'b1;
          load_type = funct3;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
          load_type  = funct3;
        end
        S_MEMWRITE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          adr_src = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
          mul_start = w_is_mul;
        end
        S_EXEC_I: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 2'b10;
        end
        S_ALUWB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a   = 2'b10;
          alu_op      = 2'b01;
          branch      = 1'b1;
          branch_type = funct3;
        end
        S_JAL, S_JALR: begin
          alu_src_a  = (r_state == S_JALR) ? 2'b10 : 2'b01;
          alu_src_b  = 2'b01;
          result_src = 2'b10;
          pc_write   = 1'b1;
          is_jalr    = (r_state == S_JALR);
        end
        S_LINK: begin
          alu_src_a  = 2'b01;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          reg_write  = 1'b1;
        end
        S_UPPER: begin
          alu_src_a = (op == OP_LUI) ? 2'b11 : 2'b01;
          alu_src_b = 2'b01;
        end
        S_MULWAIT: begin
          result_src = mul_done ? 2'b11 : 2'b00;
          reg_write  = mul_done;
        end
        default: ;
      endcase
    end
  end

  assign illegal_instr = r_illegal;
  assign state_o       = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench: random instruction stream against a cycle-level reference model
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_req;
    logic       mem_we;
    logic       reg_write;
    logic [1:0] rs;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] aop;
    logic       branch;
    logic [2:0] bt;
    logic [2:0] lt;
    logic       is_jalr;
    logic       mul_start;
    logic       illegal;
  } ctrl_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       mr;
    logic       md;
    logic       rm;
    logic       ra;
  } stim_t;

  typedef struct {
    ctrl_t m;
    ctrl_t a;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_m, rst_a, mem_ready, mul_done;
  logic [6:0] op, funct7;
  logic [2:0] funct3;

  logic       m_pcw, m_irw, m_adr, m_req, m_we, m_rw, m_br, m_jalr, m_ms, m_ill;
  logic [1:0] m_rs, m_a, m_b, m_aop;
  logic [2:0] m_bt, m_lt;
  logic [3:0] m_st;
  logic       a_pcw, a_irw, a_adr, a_req, a_we, a_rw, a_br, a_jalr, a_ms, a_ill;
  logic [1:0] a_rs, a_a, a_b, a_aop;
  logic [2:0] a_bt, a_lt;
  logic [3:0] a_st;

  multicycle_controller u_main (
    .clk(clk), .reset(rst_m), .op(op), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .mul_done(mul_done),
    .pc_write(m_pcw), .ir_write(m_irw), .adr_src(m_adr), .mem_req(m_req), .mem_we(m_we),
    .reg_write(m_rw), .result_src(m_rs), .alu_src_a(m_a), .alu_src_b(m_b), .alu_op(m_aop),
    .branch(m_br), .branch_type(m_bt), .load_type(m_lt), .is_jalr(m_jalr),
    .mul_start(m_ms), .illegal_instr(m_ill), .state_o(m_st)
  );

  multicycle_controller #(.ENABLE_M(1'b0), .TRAP_ON_ILLEGAL(1'b0)) u_alt (
    .clk(clk), .reset(rst_a), .op(op), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .mul_done(mul_done),
    .pc_write(a_pcw), .ir_write(a_irw), .adr_src(a_adr), .mem_req(a_req), .mem_we(a_we),
    .reg_write(a_rw), .result_src(a_rs), .alu_src_a(a_a), .alu_src_b(a_b), .alu_op(a_aop),
    .branch(a_br), .branch_type(a_bt), .load_type(a_lt), .is_jalr(a_jalr),
    .mul_start(a_ms), .illegal_instr(a_ill), .state_o(a_st)
  );

  ctrl_t act_m, act_a;
  assign act_m = {m_st, m_pcw, m_irw, m_adr, m_req, m_we, m_rw, m_rs, m_a, m_b, m_aop,
                  m_br, m_bt, m_lt, m_jalr, m_ms, m_ill};
  assign act_a = {a_st, a_pcw, a_irw, a_adr, a_req, a_we, a_rw, a_rs, a_a, a_b, a_aop,
                  a_br, a_bt, a_lt, a_jalr, a_ms, a_ill};

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    total = 0;
  int    bad   = 0;

  logic [6:0] g_op, g_f7;
  logic [2:0] g_f3;
  bit         g_alt, g_dead;
  int         g_left;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Control word the specification assigns to each named state, given the current inputs.
  function automatic ctrl_t exp_ctrl(int st, logic [6:0] o, logic [2:0] f3, logic [6:0] f7,
                                     logic mr, logic md, bit enm);
    ctrl_t c;
    c = '0;
    c.st = 4'(st);
    case (st)
      0:  begin c.mem_req = 1; c.b = 2'b10; c.rs = 2'b10; c.ir_write = mr; c.pc_write = mr; end
      1:  begin c.a = 2'b01; c.b = 2'b01; end
      2:  begin c.a = 2'b10; c.b = 2'b01; end
      3:  begin c.mem_req = 1; c.adr_src = 1; c.lt = f3; end
      4:  begin c.rs = 2'b01; c.reg_write = 1; c.lt = f3; end
      5:  begin c.mem_req = 1; c.mem_we = 1; c.adr_src = 1; end
      6:  begin c.a = 2'b10; c.aop = 2'b10; c.mul_start = enm && (f7 == 7'b0000001); end
      7:  begin c.a = 2'b10; c.b = 2'b01; c.aop = 2'b10; end
      8:  c.reg_write = 1;
      9:  begin c.a = 2'b10; c.aop = 2'b01; c.branch = 1; c.bt = f3; end
      10: begin c.a = 2'b01; c.b = 2'b01; c.rs = 2'b10; c.pc_write = 1; end
      11: begin c.a = 2'b10; c.b = 2'b01; c.rs = 2'b10; c.pc_write = 1; c.is_jalr = 1; end
      12: begin c.a = 2'b01; c.b = 2'b10; c.rs = 2'b10; c.reg_write = 1; end
      13: begin c.a = (o == 7'b0110111) ? 2'b11 : 2'b01; c.b = 2'b01; end
      14: begin c.reg_write = md; c.rs = md ? 2'b11 : 2'b00; end
      15: c.illegal = 1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic push(logic rm, logic ra, logic mr, logic md, ctrl_t em, ctrl_t ea);
    stim_t s;
    exp_t  e;
    s = '{op: g_op, f3: g_f3, f7: g_f7, mr: mr, md: md, rm: rm, ra: ra};
    e = '{m: em, a: ea};
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic emit_reset(int n);
    for (int i = 0; i < n; i++) push(1'b1, 1'b1, rbit(), rbit(), '0, '0);
  endtask

  task automatic emit(int st, logic mr, logic md);
    ctrl_t e;
    if (g_dead) return;
    if (g_left == 0) begin
      emit_reset($urandom_range(1, 2));
      g_dead = 1;
      return;
    end
    g_left--;
    e = exp_ctrl(st, g_op, g_f3, g_f7, mr, md, !g_alt);
    if (g_alt) push(1'b1, 1'b0, mr, md, '0, e);
    else       push(1'b0, 1'b1, mr, md, e, '0);
  endtask

  // cls: 0 add 1 op-imm 2 load 3 store 4 branch 5 jal 6 jalr 7 lui 8 auipc 9 mul 10 illegal
  task automatic run_instr(int cls, int abort_at, int fw, int wt);
    int nf, nw;
    logic [6:0] ill_ops [4];
    ill_ops = '{7'b1111111, 7'b0000000, 7'b1110011, 7'b0001111};
    nf = (fw < 0) ? $urandom_range(0, 2) : fw;
    g_f3 = 3'($urandom_range(0, 7));
    g_f7 = rbit() ? 7'b0100000 : 7'b0000000;
    case (cls)
      0: g_op = 7'b0110011;
      1: g_op = 7'b0010011;
      2: g_op = 7'b0000011;
      3: g_op = 7'b0100011;
      4: g_op = 7'b1100011;
      5: g_op = 7'b1101111;
      6: g_op = 7'b1100111;
      7: g_op = 7'b0110111;
      8: g_op = 7'b0010111;
      9: begin g_op = 7'b0110011; g_f7 = 7'b0000001; end
      default: g_op = ill_ops[$urandom_range(0, 3)];
    endcase
    if (cls == 2 && wt == 3) g_f3 = 3'b010;
    g_left = abort_at;
    g_dead = 0;
    for (int i = 0; i < nf; i++) emit(0, 1'b0, rbit());
    emit(0, 1'b1, rbit());
    emit(1, rbit(), rbit());
    case (cls)
      0, 1, 7, 8: begin
        emit((cls == 0) ? 6 : (cls == 1) ? 7 : 13, rbit(), rbit());
        emit(8, rbit(), rbit());
      end
      2, 3: begin
        nw = (wt < 0) ? $urandom_range(0, 3) : wt;
        emit(2, rbit(), rbit());
        for (int i = 0; i < nw; i++) emit((cls == 2) ? 3 : 5, 1'b0, rbit());
        emit((cls == 2) ? 3 : 5, 1'b1, rbit());
        if (cls == 2) emit(4, rbit(), rbit());
      end
      4: emit(9, rbit(), rbit());
      5, 6: begin
        emit((cls == 5) ? 10 : 11, rbit(), rbit());
        emit(12, rbit(), rbit());
      end
      9: begin
        emit(6, rbit(), rbit());
        if (g_alt) emit(8, rbit(), rbit());
        else begin
          nw = (wt < 0) ? $urandom_range(0, 5) : wt;
          for (int i = 0; i < nw; i++) emit(14, rbit(), 1'b0);
          emit(14, rbit(), 1'b1);
        end
      end
      default: begin
        if (!g_alt) begin
          nw = (wt < 0) ? $urandom_range(1, 4) : wt;
          for (int i = 0; i < nw; i++) emit(15, rbit(), rbit());
          if (!g_dead) emit_reset($urandom_range(1, 2));
        end
      end
    endcase
  endtask

  function automatic int rand_abort();
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1;
  endfunction

  initial begin
    rst_m = 1'b1; rst_a = 1'b1; mem_ready = 1'b0; mul_done = 1'b0;
    op = '0; funct3 = '0; funct7 = '0;
    g_op = '0; g_f3 = '0; g_f7 = '0; g_alt = 0;

    emit_reset(2);
    run_instr(0, -1, 0, 0);
    run_instr(2, -1, 0, 3);
    run_instr(9, -1, 1, 5);
    run_instr(6, -1, 0, 0);
    run_instr(10, -1, 0, 3);
    for (int i = 0; i < 150; i++) run_instr($urandom_range(0, 10), rand_abort(), -1, -1);
    emit_reset(1);
    g_alt = 1;
    run_instr(9, -1, 0, 0);
    run_instr(10, -1, 0, 0);
    run_instr(0, -1, 0, 0);
    for (int i = 0; i < 80; i++) run_instr($urandom_range(0, 10), rand_abort(), -1, -1);
    emit_reset(1);

    fork
      begin : driver
        stim_t s;
        while (stim_q.size() > 0) begin
          @(negedge clk);
          s = stim_q.pop_front();
          op = s.op; funct3 = s.f3; funct7 = s.f7;
          mem_ready = s.mr; mul_done = s.md;
          rst_m = s.rm; rst_a = s.ra;
        end
      end
      begin : monitor
        exp_t e;
        int   cyc;
        cyc = 0;
        while (exp_q.size() > 0) begin
          @(negedge clk);
          #2;
          e = exp_q.pop_front();
          total++;
          if (act_m !== e.m) begin
            bad++;
            $display("FAIL ctrl_main cycle=%0d got=%h want=%h", cyc, act_m, e.m);
          end
          total++;
          if (act_a !== e.a) begin
            bad++;
            $display("FAIL ctrl_alt cycle=%0d got=%h want=%h", cyc, act_a, e.a);
          end
          cyc++;
        end
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
